vga_timing_param: RTL and testbench



---
 rtl/vga_timing_param.sv | 109 ++++++++++
 tb/tb_vga_timing_param.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_param.sv
// Parametrised VGA/VESA timing generator: pixel/line counters plus registered sync, blank, de and sof.
// Define VGA_TIMING_FRAME_CNT_EN to build the 16-bit frame counter; otherwise frame_cnt is tied to zero.
module vga_timing_param #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23,
  parameter logic        HS_POL   = 1'b1,
  parameter logic        VS_POL   = 1'b1,
  parameter int unsigned CW       = 11
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          hblnk,
  output logic          vblnk,
  output logic          de,
  output logic          sof,
  output logic [15:0]   frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic          h_last;
  logic          v_last;
  logic          frame_wrap;
  logic [CW-1:0] h_nxt;
  logic [CW-1:0] v_nxt;
  logic          hblnk_nxt;
  logic          vblnk_nxt;
  logic          hsync_nxt;
  logic          vsync_nxt;

  // Outputs are decoded from the next counter values so they register on the same edge as the counters.
  always_comb begin
    h_last     = (hcount == H_LAST);
    v_last     = (vcount == V_LAST);
    frame_wrap = h_last && v_last;
    h_nxt      = h_last ? '0 : hcount + 1'b1;
    v_nxt      = vcount;
    if (h_last) begin
      v_nxt = v_last ? '0 : vcount + 1'b1;
    end
    hblnk_nxt = (h_nxt >= H_ACT_C);
    vblnk_nxt = (v_nxt >= V_ACT_C);
    hsync_nxt = ((h_nxt >= HS_START) && (h_nxt <= HS_END)) ? HS_POL : ~HS_POL;
    vsync_nxt = ((v_nxt >= VS_START) && (v_nxt <= VS_END)) ? VS_POL : ~VS_POL;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hcount <= '0;
      vcount <= '0;
      hblnk  <= 1'b0;
      vblnk  <= 1'b0;
      de     <= 1'b1;
      hsync  <= ~HS_POL;
      vsync  <= ~VS_POL;
      sof    <= 1'b0;
    end else if (en) begin
      hcount <= h_nxt;
      vcount <= v_nxt;
      hblnk  <= hblnk_nxt;
      vblnk  <= vblnk_nxt;
      de     <= ~hblnk_nxt & ~vblnk_nxt;
      hsync  <= hsync_nxt;
      vsync  <= vsync_nxt;
      sof    <= frame_wrap;
    end else begin
      sof    <= 1'b0;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_q;

  // Counts on the wrap edge itself, so the new value appears in the same cycle as sof.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
    end else if (en && frame_wrap) begin
      frame_q <= frame_q + 16'd1;
    end
  end

  assign frame_cnt = frame_q;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_param.sv
// Bench for vga_timing_param: default, small-frame (negative polarity) and 640x480-line instances.
module tb_vga_timing_param;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;
  int preload_events = 0;

`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  // Instance A: default 800x600 timing
  logic        rst_a, en_a;
  logic [10:0] a_hcount, a_vcount;
  logic        a_hsync, a_vsync, a_hblnk, a_vblnk, a_de, a_sof;
  logic [15:0] a_frame_cnt;

  vga_timing_param dut_a (
    .pclk(pclk), .rst(rst_a), .en(en_a),
    .hcount(a_hcount), .vcount(a_vcount), .hsync(a_hsync), .vsync(a_vsync),
    .hblnk(a_hblnk), .vblnk(a_vblnk), .de(a_de), .sof(a_sof), .frame_cnt(a_frame_cnt)
  );

  // Instance B: 23 x 16 frame, active-low syncs; small enough to run whole frames
  logic       rst_b, en_b;
  logic [5:0] b_hcount, b_vcount;
  logic       b_hsync, b_vsync, b_hblnk, b_vblnk, b_de, b_sof;
  logic [15:0] b_frame_cnt;

  vga_timing_param #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(6)
  ) dut_b (
    .pclk(pclk), .rst(rst_b), .en(en_b),
    .hcount(b_hcount), .vcount(b_vcount), .hsync(b_hsync), .vsync(b_vsync),
    .hblnk(b_hblnk), .vblnk(b_vblnk), .de(b_de), .sof(b_sof), .frame_cnt(b_frame_cnt)
  );

  // Instance C: 640x480 timing, active-low syncs
  logic       rst_c, en_c;
  logic [9:0] c_hcount, c_vcount;
  logic       c_hsync, c_vsync, c_hblnk, c_vblnk, c_de, c_sof;
  logic [15:0] c_frame_cnt;

  vga_timing_param #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(10)
  ) dut_c (
    .pclk(pclk), .rst(rst_c), .en(en_c),
    .hcount(c_hcount), .vcount(c_vcount), .hsync(c_hsync), .vsync(c_vsync),
    .hblnk(c_hblnk), .vblnk(c_vblnk), .de(c_de), .sof(c_sof), .frame_cnt(c_frame_cnt)
  );

  typedef struct packed {
    logic [5:0]  h;
    logic [5:0]  v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        de;
    logic        sof;
    logic [15:0] fc;
  } obs_t;

  obs_t sb_q[$];

  // Expected instance-B outputs at position (h, v): syncs 18..20 / lines 11..12, active 16 x 10.
  function automatic obs_t exp_b(int h, int v, logic s, logic [15:0] fc);
    obs_t o;
    o.h   = 6'(h);
    o.v   = 6'(v);
    o.hb  = (h >= 16);
    o.vb  = (v >= 10);
    o.de  = !o.hb && !o.vb;
    o.hs  = (h >= 18 && h <= 20) ? 1'b0 : 1'b1;
    o.vs  = (v >= 11 && v <= 12) ? 1'b0 : 1'b1;
    o.sof = s;
    o.fc  = fc;
    return o;
  endfunction

  // Reference model of instance B: pushes the expectation at each edge, compares 1 time unit later.
  task automatic scoreboard_b();
    int          mh = 0;
    int          mv = 0;
    logic        msof = 1'b0;
    logic [15:0] mfc = '0;
    int          seen_pre = 0;
    obs_t        e;
    obs_t        act;
    forever begin
      @(posedge pclk);
      if (rst_b) begin
        mh = 0; mv = 0; msof = 1'b0; mfc = '0;
      end else begin
        if (preload_events != seen_pre) begin
          seen_pre = preload_events;
          mfc = 16'hFFFF;
        end
        if (en_b) begin
          msof = (mh == 22 && mv == 15);
          if (msof && FC_EN) mfc = mfc + 16'd1;
          if (mh == 22) begin
            mh = 0;
            mv = (mv == 15) ? 0 : mv + 1;
          end else begin
            mh = mh + 1;
          end
        end else begin
          msof = 1'b0;
        end
      end
      sb_q.push_back(exp_b(mh, mv, msof, mfc));
      #1;
      e   = sb_q.pop_front();
      act = {b_hcount, b_vcount, b_hsync, b_vsync, b_hblnk, b_vblnk, b_de, b_sof, b_frame_cnt};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL sb_b t=%0t got h=%0d v=%0d hs%b vs%b hb%b vb%b de%b sof%b fc%h exp h=%0d v=%0d hs%b vs%b hb%b vb%b de%b sof%b fc%h",
                 $time, act.h, act.v, act.hs, act.vs, act.hb, act.vb, act.de, act.sof, act.fc,
                 e.h, e.v, e.hs, e.vs, e.hb, e.vb, e.de, e.sof, e.fc);
      end
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (a_hcount !== 11'd0) begin errors++; $display("FAIL rst_hcount got %0d exp 0", a_hcount); end
    checks++; if (a_vcount !== 11'd0) begin errors++; $display("FAIL rst_vcount got %0d exp 0", a_vcount); end
    checks++; if ({a_hblnk, a_vblnk, a_de} !== 3'b001) begin errors++; $display("FAIL rst_blank got %b exp 001", {a_hblnk, a_vblnk, a_de}); end
    checks++; if ({a_hsync, a_vsync} !== 2'b00) begin errors++; $display("FAIL rst_sync_pos got %b exp 00", {a_hsync, a_vsync}); end
    checks++; if (a_sof !== 1'b0) begin errors++; $display("FAIL rst_sof got %b exp 0", a_sof); end
    checks++; if (a_frame_cnt !== 16'h0) begin errors++; $display("FAIL rst_fc got %h exp 0000", a_frame_cnt); end
    checks++;
    if ({c_hcount, c_vcount, c_hsync, c_vsync, c_hblnk, c_vblnk, c_de, c_sof, c_frame_cnt} !==
        {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL rst_c got h=%0d v=%0d hs%b vs%b hb%b vb%b de%b sof%b fc%h exp neg-pol reset state",
               c_hcount, c_vcount, c_hsync, c_vsync, c_hblnk, c_vblnk, c_de, c_sof, c_frame_cnt);
    end
    rst_a = 1'b0;
  endtask

  // Edge n after reset release shows hcount = n mod 1056.
  task automatic test_line_default();
    for (int n = 1; n <= 1060; n++) begin
      @(posedge pclk); #1;
      case (n)
        799: begin
          checks++; if (a_hcount !== 11'd799 || a_hblnk !== 1'b0) begin errors++; $display("FAIL hblnk_799 got h=%0d hb=%b exp 799/0", a_hcount, a_hblnk); end
        end
        800: begin
          checks++; if (a_hblnk !== 1'b1 || a_de !== 1'b0) begin errors++; $display("FAIL hblnk_800 got hb=%b de=%b exp 1/0", a_hblnk, a_de); end
        end
        839: begin
          checks++; if (a_hsync !== 1'b0) begin errors++; $display("FAIL hsync_839 got %b exp 0", a_hsync); end
        end
        840: begin
          checks++; if (a_hsync !== 1'b1) begin errors++; $display("FAIL hsync_840 got %b exp 1", a_hsync); end
        end
        967: begin
          checks++; if (a_hsync !== 1'b1) begin errors++; $display("FAIL hsync_967 got %b exp 1", a_hsync); end
        end
        968: begin
          checks++; if (a_hsync !== 1'b0) begin errors++; $display("FAIL hsync_968 got %b exp 0", a_hsync); end
        end
        1055: begin
          checks++; if (a_hcount !== 11'd1055 || a_vcount !== 11'd0) begin errors++; $display("FAIL line_end got h=%0d v=%0d exp 1055/0", a_hcount, a_vcount); end
        end
        1056: begin
          checks++;
          if (a_hcount !== 11'd0 || a_vcount !== 11'd1 || a_hblnk !== 1'b0 || a_de !== 1'b1 || a_vsync !== 1'b0) begin
            errors++;
            $display("FAIL line_wrap got h=%0d v=%0d hb=%b de=%b vs=%b exp 0/1/0/1/0", a_hcount, a_vcount, a_hblnk, a_de, a_vsync);
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_en_hold();
    int cnt;
    for (int n = 0; n < 496; n++) begin
      @(posedge pclk); #1;
    end
    checks++; if (a_hcount !== 11'd500 || a_vcount !== 11'd1) begin errors++; $display("FAIL hold_pos got h=%0d v=%0d exp 500/1", a_hcount, a_vcount); end
    en_a = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(posedge pclk); #1;
      checks++;
      if ({a_hcount, a_vcount, a_hsync, a_vsync, a_hblnk, a_vblnk, a_de, a_sof} !==
          {11'd500, 11'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL hold_freeze got h=%0d v=%0d hs%b vs%b hb%b vb%b de%b sof%b exp 500/1 000010",
                 a_hcount, a_vcount, a_hsync, a_vsync, a_hblnk, a_vblnk, a_de, a_sof);
      end
    end
    en_a = 1'b1;
    cnt = 0;
    do begin
      @(posedge pclk); #1;
      cnt++;
    end while (a_hcount !== 11'd0 && cnt < 1000);
    checks++; if (cnt != 556) begin errors++; $display("FAIL hold_wrap_delay got %0d exp 556 edges after resume", cnt); end
    checks++; if (a_vcount !== 11'd2) begin errors++; $display("FAIL hold_vcount got %0d exp 2", a_vcount); end
  endtask

  task automatic test_polarity_640();
    rst_c = 1'b0;
    for (int n = 1; n <= 801; n++) begin
      int  h;
      logic exp_hs;
      @(posedge pclk); #1;
      h = n % 800;
      exp_hs = (h >= 656 && h <= 751) ? 1'b0 : 1'b1;
      checks++;
      if (c_hcount !== 10'(h) || c_hsync !== exp_hs || c_vsync !== 1'b1) begin
        errors++;
        $display("FAIL c_hsync n=%0d got h=%0d hs=%b vs=%b exp h=%0d hs=%b vs=1", n, c_hcount, c_hsync, c_vsync, h, exp_hs);
      end
      if (n == 800) begin
        checks++; if (c_vcount !== 10'd1) begin errors++; $display("FAIL c_line_len got v=%0d exp 1 after 800 edges", c_vcount); end
      end
    end
  endtask

  task automatic test_frame_b();
    int de_cnt = 0;
    int sof_cnt = 0;
    rst_b = 1'b0;
    for (int n = 1; n <= 741; n++) begin
      int h;
      int v;
      @(posedge pclk); #1;
      h = n % 23;
      v = (n / 23) % 16;
      checks++;
      if (b_sof !== (n % 368 == 0)) begin errors++; $display("FAIL b_sof n=%0d got %b exp %b", n, b_sof, (n % 368 == 0)); end
      if (b_sof === 1'b1) sof_cnt++;
      if (n >= 368 && n < 736 && b_de === 1'b1) de_cnt++;
      if (h == 0 && v == 10) begin
        checks++; if (b_vblnk !== 1'b1) begin errors++; $display("FAIL b_vblnk_rise got %b exp 1", b_vblnk); end
      end
      if (h == 22 && v == 9) begin
        checks++; if (b_vblnk !== 1'b0) begin errors++; $display("FAIL b_vblnk_pre got %b exp 0", b_vblnk); end
      end
      checks++;
      if (b_vsync !== ((v == 11 || v == 12) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL b_vsync n=%0d v=%0d h=%0d got %b", n, v, h, b_vsync); end
    end
    checks++; if (de_cnt != 160) begin errors++; $display("FAIL b_de_count got %0d exp 160", de_cnt); end
    checks++; if (sof_cnt != 2) begin errors++; $display("FAIL b_sof_count got %0d exp 2", sof_cnt); end
  endtask

  task automatic test_wrap_hold_b();
    for (int n = 0; n < 362; n++) begin
      @(posedge pclk); #1;
    end
    checks++; if (b_hcount !== 6'd22 || b_vcount !== 6'd15) begin errors++; $display("FAIL whold_pos got %0d/%0d exp 22/15", b_hcount, b_vcount); end
    en_b = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(posedge pclk); #1;
      checks++;
      if (b_hcount !== 6'd22 || b_vcount !== 6'd15 || b_sof !== 1'b0) begin
        errors++;
        $display("FAIL whold_freeze got %0d/%0d sof=%b exp 22/15/0", b_hcount, b_vcount, b_sof);
      end
    end
    en_b = 1'b1;
    @(posedge pclk); #1;
    checks++; if (b_hcount !== 6'd0 || b_vcount !== 6'd0 || b_sof !== 1'b1) begin errors++; $display("FAIL whold_resume got %0d/%0d sof=%b exp 0/0/1", b_hcount, b_vcount, b_sof); end
    @(posedge pclk); #1;
    checks++; if (b_hcount !== 6'd1 || b_sof !== 1'b0) begin errors++; $display("FAIL whold_sof_width got h=%0d sof=%b exp 1/0", b_hcount, b_sof); end
  endtask

  task automatic test_frame_cnt();
`ifdef VGA_TIMING_FRAME_CNT_EN
    int n;
    checks++; if (b_frame_cnt !== 16'd3) begin errors++; $display("FAIL fc_three got %0d exp 3", b_frame_cnt); end
    force dut_b.frame_q = 16'hFFFF;
    preload_events++;
    @(posedge pclk); #1;
    release dut_b.frame_q;
    checks++; if (b_frame_cnt !== 16'hFFFF) begin errors++; $display("FAIL fc_preload got %h exp ffff", b_frame_cnt); end
    n = 0;
    do begin
      @(posedge pclk); #1;
      n++;
    end while (b_sof !== 1'b1 && n < 400);
    checks++; if (b_sof !== 1'b1 || b_frame_cnt !== 16'h0) begin errors++; $display("FAIL fc_wrap got sof=%b fc=%h exp 1/0000", b_sof, b_frame_cnt); end
`else
    checks++; if (b_frame_cnt !== 16'h0 || a_frame_cnt !== 16'h0) begin errors++; $display("FAIL fc_tied got %h/%h exp 0000", b_frame_cnt, a_frame_cnt); end
`endif
  endtask

  task automatic test_reset_mid_b();
    for (int i = 0; i < 400 && !(b_hcount == 6'd18 && b_vcount == 6'd11); i++) begin
      @(posedge pclk); #1;
    end
    checks++; if (b_hcount !== 6'd18 || b_vcount !== 6'd11 || b_hsync !== 1'b0 || b_vsync !== 1'b0) begin
      errors++; $display("FAIL rmid_reach got %0d/%0d hs=%b vs=%b exp 18/11/0/0", b_hcount, b_vcount, b_hsync, b_vsync);
    end
    #3 rst_b = 1'b1;
    #1;
    checks++;
    if ({b_hcount, b_vcount, b_hsync, b_vsync, b_hblnk, b_vblnk, b_de, b_sof, b_frame_cnt} !==
        {6'd0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL rmid_async got h=%0d v=%0d hs%b vs%b hb%b vb%b de%b sof%b fc%h exp reset state",
               b_hcount, b_vcount, b_hsync, b_vsync, b_hblnk, b_vblnk, b_de, b_sof, b_frame_cnt);
    end
    @(posedge pclk); #1;
    #2 rst_b = 1'b0;
    @(posedge pclk); #1;
    checks++; if (b_hcount !== 6'd1 || b_vcount !== 6'd0) begin errors++; $display("FAIL rmid_restart got %0d/%0d exp 1/0", b_hcount, b_vcount); end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    en_a  = 1'b1; en_b  = 1'b1; en_c  = 1'b1;
    fork
      scoreboard_b();
    join_none
    test_reset();
    test_line_default();
    test_en_hold();
    test_polarity_640();
    test_frame_b();
    test_wrap_hold_b();
    test_frame_cnt();
    test_reset_mid_b();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
